// File: rtl/clk_ratio_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_ratio_monitor_if
// Description : Bundles the control input, the clock under test and all
//               measurement/status outputs of clk_ratio_monitor.
//               master = stimulus side, slave = monitor side.
// Revision    : 1.0  initial release
// ============================================================================
interface clk_ratio_monitor_if #(
  parameter int W = 4
);
  logic         enable;
  logic         div_clk_in;
  logic [W-1:0] measured_ratio;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic         ratio_valid;
  logic         locked;
  logic         mismatch;
  logic         overflow;

  modport master (
    output enable, div_clk_in,
    input  measured_ratio, high_len, low_len, ratio_valid, locked, mismatch, overflow
  );

  modport slave (
    input  enable, div_clk_in,
    output measured_ratio, high_len, low_len, ratio_valid, locked, mismatch, overflow
  );
endinterface
`default_nettype wire

// File: rtl/clk_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_ratio_monitor
// Description : Measures high phase, low phase and full period (in ref_clk
//               cycles) of a divided clock. Reports lock on a stable ratio,
//               a mismatch pulse on a ratio change while locked, and a sticky
//               overflow when a phase or the period does not fit in W bits.
//               Optional macro CLK_MON_SYNC_EN inserts a 2-flop synchronizer
//               in front of the sample flop (adds 2 cycles of latency).
// Revision    : 1.0  initial release
// ============================================================================
module clk_ratio_monitor #(
  parameter int DIV_RATIO_WIDTH = 4,
  parameter int LOCK_COUNT      = 4
) (
  input  wire logic          ref_clk,
  input  wire logic          reset,
  clk_ratio_monitor_if.slave mon
);

  localparam int               W            = DIV_RATIO_WIDTH;
  localparam logic [W-1:0]     c_CNT_MAX    = {W{1'b1}};
  localparam logic [W-1:0]     c_CNT_ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       c_LOCK_COUNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         w_din;
  logic         r_s;
  logic         r_prev;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_hl;
  logic [W-1:0] r_ref;
  logic [3:0]   r_lock_cnt;
  logic [3:0]   w_lock_inc;

  logic [W-1:0] r_measured_ratio;
  logic [W-1:0] r_high_len;
  logic [W-1:0] r_low_len;
  logic         r_ratio_valid;
  logic         r_locked;
  logic         r_mismatch;
  logic         r_overflow;

  logic         w_rise;
  logic         w_fall;
  logic         w_edge;
  logic [W:0]   w_sum;
  logic         w_phase_ovf;
  logic         w_sum_ovf;
  logic         w_ovf_evt;
  logic         w_done;

`ifdef CLK_MON_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for a div_clk_in from an unrelated clock domain
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mon.div_clk_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_din = r_sync2;
`else
  assign w_din = mon.div_clk_in;
`endif

  // Sample flop plus delayed copy for edge detection
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_s    <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s    <= w_din;
      r_prev <= r_s;
    end
  end

  assign w_rise = r_s & ~r_prev;
  assign w_fall = ~r_s & r_prev;
  assign w_edge = w_rise | w_fall;

  // Period is high length plus the low length counted so far, one bit wider
  // so a period that does not fit in W bits is detectable
  assign w_sum       = {1'b0, r_hl} + {1'b0, r_cnt};
  assign w_phase_ovf = (r_state != IDLE) && (r_cnt == c_CNT_MAX) && !w_edge;
  assign w_sum_ovf   = (r_state == MEAS_LOW) && w_rise && w_sum[W];
  assign w_ovf_evt   = mon.enable && (w_phase_ovf || w_sum_ovf);
  assign w_done      = mon.enable && !r_overflow && (r_state == MEAS_LOW) &&
                       w_rise && !w_sum[W];

  // Lock counter advance, saturating at the lock threshold
  assign w_lock_inc  = (r_lock_cnt == c_LOCK_COUNT) ? r_lock_cnt : r_lock_cnt + 4'd1;

  // Phase counter restarts at 1 on every edge and saturates at all-ones
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!mon.enable) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= c_CNT_ONE;
    end else if (r_cnt != c_CNT_MAX) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // Latch the high-phase length when the high phase ends
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_hl <= '0;
    end else if (!mon.enable) begin
      r_hl <= '0;
    end else if ((r_state == MEAS_HIGH) && w_fall) begin
      r_hl <= r_cnt;
    end
  end

  // FSM state register
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; overflow parks the FSM in WAIT_RISE until enable drops
  always_comb begin
    w_state_nxt = r_state;
    if (!mon.enable) begin
      w_state_nxt = IDLE;
    end else if (r_overflow || w_ovf_evt) begin
      w_state_nxt = WAIT_RISE;
    end else begin
      case (r_state)
        IDLE:      w_state_nxt = WAIT_RISE;
        WAIT_RISE: if (w_rise) w_state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (w_fall) w_state_nxt = MEAS_LOW;
        MEAS_LOW:  if (w_rise) w_state_nxt = MEAS_HIGH;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  // Result registers, lock tracking and status flags
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_measured_ratio <= '0;
      r_high_len       <= '0;
      r_low_len        <= '0;
      r_ratio_valid    <= 1'b0;
      r_locked         <= 1'b0;
      r_mismatch       <= 1'b0;
      r_overflow       <= 1'b0;
      r_ref            <= '0;
      r_lock_cnt       <= 4'd0;
    end else if (!mon.enable) begin
      // Last results are kept for software to read after stopping
      r_ratio_valid    <= 1'b0;
      r_locked         <= 1'b0;
      r_mismatch       <= 1'b0;
      r_overflow       <= 1'b0;
      r_lock_cnt       <= 4'd0;
    end else begin
      r_ratio_valid    <= 1'b0;
      r_mismatch       <= 1'b0;
      if (w_ovf_evt) begin
        r_overflow     <= 1'b1;
        r_locked       <= 1'b0;
        r_lock_cnt     <= 4'd0;
      end else if (w_done) begin
        r_ratio_valid    <= 1'b1;
        r_measured_ratio <= w_sum[W-1:0];
        r_high_len       <= r_hl;
        r_low_len        <= r_cnt;
        if (r_lock_cnt == 4'd0) begin
          r_ref      <= w_sum[W-1:0];
          r_lock_cnt <= 4'd1;
          r_locked   <= (c_LOCK_COUNT == 4'd1);
        end else if (w_sum[W-1:0] == r_ref) begin
          r_lock_cnt <= w_lock_inc;
          r_locked   <= (w_lock_inc == c_LOCK_COUNT);
        end else begin
          r_ref      <= w_sum[W-1:0];
          r_lock_cnt <= 4'd1;
          r_locked   <= 1'b0;
          r_mismatch <= r_locked;
        end
      end
    end
  end

  assign mon.measured_ratio = r_measured_ratio;
  assign mon.high_len       = r_high_len;
  assign mon.low_len        = r_low_len;
  assign mon.ratio_valid    = r_ratio_valid;
  assign mon.locked         = r_locked;
  assign mon.mismatch       = r_mismatch;
  assign mon.overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_ratio_monitor
// Description : Self-checking bench for clk_ratio_monitor (W=4, LOCK_COUNT=4).
//               Expected periods are pushed to a queue as the divided clock
//               is driven and compared when ratio_valid pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_clk_ratio_monitor;

  localparam int W    = 4;
  localparam int LOCK = 4;

  typedef struct {
    logic [W-1:0] ratio;
    logic [W-1:0] high;
    logic [W-1:0] low;
    logic         locked;
    logic         mismatch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_ratio_monitor_if #(.W(W)) bus ();

  clk_ratio_monitor #(
    .DIV_RATIO_WIDTH (W),
    .LOCK_COUNT      (LOCK)
  ) dut (
    .ref_clk (clk),
    .reset   (rst),
    .mon     (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  // Stimulus-side model of the measurement
  int   tb_high  = 0;
  int   tb_low   = 0;
  bit   tb_prev  = 1'b0;
  bit   tb_meas  = 1'b0;
  bit   tb_track = 1'b0;
  int   m_ref    = 0;
  int   m_lcnt   = 0;
  bit   m_locked = 1'b0;

  task automatic model_clear();
    m_lcnt   = 0;
    m_locked = 1'b0;
    tb_meas  = 1'b0;
  endtask

  task automatic model_rise();
    exp_t e;
    int   r;
    if (tb_meas && tb_high > 0 && tb_low > 0) begin
      r = tb_high + tb_low;
      if (r > 15) begin
        model_clear();
        tb_track = 1'b0;
      end else begin
        e.mismatch = 1'b0;
        if (m_lcnt == 0) begin
          m_ref  = r;
          m_lcnt = 1;
        end else if (r == m_ref) begin
          if (m_lcnt < LOCK) m_lcnt++;
        end else begin
          e.mismatch = m_locked;
          m_ref      = r;
          m_lcnt     = 1;
        end
        m_locked = (m_lcnt == LOCK);
        e.ratio  = 4'(r);
        e.high   = 4'(tb_high);
        e.low    = 4'(tb_low);
        e.locked = m_locked;
        sb.push_back(e);
      end
    end
    tb_meas = tb_track;
    tb_high = 0;
    tb_low  = 0;
  endtask

  task automatic drive_bit(input bit v);
    @(posedge clk);
    #1;
    bus.div_clk_in = v;
    if (v && !tb_prev) model_rise();
    if (v) tb_high++;
    else if (tb_high > 0) tb_low++;
    tb_prev = v;
  endtask

  task automatic run_pattern(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      repeat (h) drive_bit(1'b1);
      repeat (l) drive_bit(1'b0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // Scoreboard: every ratio_valid pulse consumes one expected period
  always @(negedge clk) begin
    if (bus.mismatch === 1'b1 && bus.ratio_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL mismatch_alone: mismatch=%b ratio_valid=%b, required mismatch only with ratio_valid",
               bus.mismatch, bus.ratio_valid);
    end
    if (bus.ratio_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: ratio_valid=1 ratio=%0d, required no pulse", bus.measured_ratio);
      end else begin
        m_e = sb.pop_front();
        checks++;
        if (bus.measured_ratio !== m_e.ratio) begin
          errors++;
          $display("FAIL sb_ratio: got %0d required %0d", bus.measured_ratio, m_e.ratio);
        end
        checks++;
        if (bus.high_len !== m_e.high) begin
          errors++;
          $display("FAIL sb_high_len: got %0d required %0d", bus.high_len, m_e.high);
        end
        checks++;
        if (bus.low_len !== m_e.low) begin
          errors++;
          $display("FAIL sb_low_len: got %0d required %0d", bus.low_len, m_e.low);
        end
        checks++;
        if (bus.locked !== m_e.locked) begin
          errors++;
          $display("FAIL sb_locked: got %b required %b", bus.locked, m_e.locked);
        end
        checks++;
        if (bus.mismatch !== m_e.mismatch) begin
          errors++;
          $display("FAIL sb_mismatch: got %b required %b", bus.mismatch, m_e.mismatch);
        end
      end
    end
  end

  task automatic test_reset();
    bus.enable     = 1'b0;
    bus.div_clk_in = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.measured_ratio, bus.high_len, bus.low_len} !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: got %h required 000", {bus.measured_ratio, bus.high_len, bus.low_len});
    end
    checks++;
    if ({bus.ratio_valid, bus.locked, bus.mismatch, bus.overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000",
               {bus.ratio_valid, bus.locked, bus.mismatch, bus.overflow});
    end
    rst = 1'b0;
  endtask

  task automatic test_div4();
    bus.enable = 1'b1;
    tb_track   = 1'b1;
    model_clear();
    repeat (3) drive_bit(1'b0);
    run_pattern(2, 2, 6);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL div4_drain: pending %0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL div4_locked: got %b required 1", bus.locked);
    end
  endtask

  task automatic test_div6();
    run_pattern(3, 3, 5);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL div6_drain: pending %0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.measured_ratio !== 4'd6) begin
      errors++;
      $display("FAIL div6_relock: got locked=%b ratio=%0d required locked=1 ratio=6",
               bus.locked, bus.measured_ratio);
    end
  endtask

  task automatic test_div5();
    run_pattern(3, 2, 6);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL div5_drain: pending %0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.measured_ratio !== 4'd5 || bus.high_len !== 4'd3 || bus.low_len !== 4'd2) begin
      errors++;
      $display("FAIL div5_values: got %0d/%0d/%0d required 5/3/2",
               bus.measured_ratio, bus.high_len, bus.low_len);
    end
  endtask

  task automatic test_overflow();
    tb_track = 1'b0;
    tb_meas  = 1'b0;
    repeat (8) drive_bit(1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got %b required 0", bus.overflow);
    end
    repeat (12) drive_bit(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.overflow !== 1'b1 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL ovf_stuck_low: got overflow=%b locked=%b required 1/0", bus.overflow, bus.locked);
    end
    run_pattern(3, 2, 4);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", bus.overflow);
    end
    bus.enable = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (bus.overflow !== 1'b0 || bus.locked !== 1'b0 || bus.measured_ratio !== 4'd5) begin
      errors++;
      $display("FAIL ovf_clear: got overflow=%b locked=%b ratio=%0d required 0/0/5",
               bus.overflow, bus.locked, bus.measured_ratio);
    end
  endtask

  task automatic test_enable_drop();
    bus.enable = 1'b1;
    tb_track   = 1'b1;
    model_clear();
    repeat (3) drive_bit(1'b0);
    run_pattern(2, 2, 6);
    wait_drain();
    checks++;
    if (sb.size() != 0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL drop_prelock: got pending=%0d locked=%b required 0/1", sb.size(), bus.locked);
      sb.delete();
    end
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    tb_track   = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (bus.locked !== 1'b0 || bus.overflow !== 1'b0 || bus.measured_ratio !== 4'd4) begin
      errors++;
      $display("FAIL drop_state: got locked=%b overflow=%b ratio=%0d required 0/0/4",
               bus.locked, bus.overflow, bus.measured_ratio);
    end
  endtask

  task automatic test_enable_race();
    bus.enable = 1'b1;
    tb_track   = 1'b1;
    model_clear();
    repeat (3) drive_bit(1'b0);
    run_pattern(3, 3, 3);
    wait_drain();
    checks++;
    if (sb.size() != 0 || bus.measured_ratio !== 4'd6) begin
      errors++;
      $display("FAIL race_pre: got pending=%0d ratio=%0d required 0/6", sb.size(), bus.measured_ratio);
      sb.delete();
    end
    // Closing rise of the pending period lands in the same cycle enable drops
    tb_meas = 1'b0;
    drive_bit(1'b1);
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    tb_track   = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    checks++;
    if (bus.measured_ratio !== 4'd6 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL race_hold: got ratio=%0d locked=%b required 6/0", bus.measured_ratio, bus.locked);
    end
  endtask

  task automatic test_max_period();
    bus.enable = 1'b1;
    tb_track   = 1'b1;
    model_clear();
    repeat (3) drive_bit(1'b0);
    run_pattern(7, 8, 2);
    run_pattern(8, 8, 2);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL max_drain: pending %0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.locked !== 1'b0 || bus.measured_ratio !== 4'd15) begin
      errors++;
      $display("FAIL max_sum_ovf: got overflow=%b locked=%b ratio=%0d required 1/0/15",
               bus.overflow, bus.locked, bus.measured_ratio);
    end
    bus.enable = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bus.enable = 1'b1;
    tb_track   = 1'b1;
    model_clear();
    repeat (3) drive_bit(1'b0);
    run_pattern(2, 2, 5);
    wait_drain();
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_prelock: got %b required 1", bus.locked);
    end
    repeat (2) drive_bit(1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.measured_ratio, bus.high_len, bus.low_len, bus.ratio_valid,
         bus.locked, bus.mismatch, bus.overflow} !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got ratio=%0d high=%0d low=%0d flags=%b required all 0",
               bus.measured_ratio, bus.high_len, bus.low_len,
               {bus.ratio_valid, bus.locked, bus.mismatch, bus.overflow});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    repeat (2) drive_bit(1'b0);
    run_pattern(2, 2, 3);
    wait_drain();
    checks++;
    if (sb.size() != 0 || bus.measured_ratio !== 4'd4 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart: got pending=%0d ratio=%0d locked=%b required 0/4/0",
               sb.size(), bus.measured_ratio, bus.locked);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div6();
    test_div5();
    test_overflow();
    test_enable_drop();
    test_enable_race();
    test_max_period();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
